fsm_table_sequencer: RTL and testbench

- Programmable, table-driven Moore/Mealy FSM engine with its own run controller.
- A host loads a 16-entry next-state/output table over a valid/ready config port, then issues start with an initial state and a step budget.
- The block steps the table FSM once per clock on input `a` until the budget is spent, then pulses `done`.
- Replaces hand-coded per-machine state tables: one configurable block serves any 3-bit-state, 1-bit-input, 3-bit-output machine.

---
 rtl/fsm_table_pkg.sv | 20 ++
 rtl/fsm_table_mem.sv | 35 +++
 rtl/fsm_table_sequencer.sv | 110 +++++++++++
 tb/tb_fsm_table_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_table_pkg.sv
// Shared types and defaults for the table-driven FSM sequencer.
// Entry layout is {next_state, output}; address is {a, state}.
package fsm_table_pkg;

    localparam int SW_DEF = 3;
    localparam int OW_DEF = 3;
    localparam int CW_DEF = 8;

    localparam int ENT_W_DEF   = SW_DEF + OW_DEF;
    localparam int NS_MSB_DEF  = ENT_W_DEF - 1;
    localparam int NS_LSB_DEF  = OW_DEF;
    localparam int OUT_MSB_DEF = OW_DEF - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ctrl_e;

endpackage

// File: rtl/fsm_table_mem.sv
// Next-state/output table: async-cleared register file,
// one synchronous write port, one combinational read port.
module fsm_table_mem
    import fsm_table_pkg::*;
#(
    parameter int AW = SW_DEF + 1,
    parameter int DW = ENT_W_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];

    // Table storage: whole table clears on reset, host writes otherwise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fsm_table_sequencer.sv
// Programmable table FSM with a run controller: host loads the table,
// then starts a run of a fixed number of transitions.
module fsm_table_sequencer
    import fsm_table_pkg::*;
#(
    parameter int SW = SW_DEF,
    parameter int OW = OW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic             clk,
    input  logic             res,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SW:0]      cfg_addr,
    input  logic [SW+OW-1:0] cfg_data,
    input  logic             start,
    input  logic [SW-1:0]    init_state,
    input  logic [CW-1:0]    steps,
    input  logic             a,
    output logic [SW-1:0]    state,
    output logic [OW-1:0]    saida,
    output logic             busy,
    output logic             done,
    output logic             err
);

    ctrl_e              r_ctrl;
    ctrl_e              w_ctrl_nxt;
    logic [SW-1:0]      r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_err;
    logic [SW+OW-1:0]   w_entry;
    logic [SW-1:0]      w_nxt;
    logic               w_idle;
    logic               w_we;

    assign w_idle = (r_ctrl == IDLE);
    assign w_we   = cfg_valid & w_idle;
    assign w_nxt  = w_entry[SW+OW-1:OW];

    fsm_table_mem #(
        .AW(SW + 1),
        .DW(SW + OW)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (res),
        .i_we    (w_we),
        .i_waddr (cfg_addr),
        .i_wdata (cfg_data),
        .i_raddr ({a, r_state}),
        .o_rdata (w_entry)
    );

    // Controller next state: a zero budget skips RUN entirely
    always_comb begin
        w_ctrl_nxt = r_ctrl;
        unique case (r_ctrl)
            IDLE: begin
                if (start) begin
                    w_ctrl_nxt = (steps == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_cnt == CW'(1)) begin
                    w_ctrl_nxt = DONE;
                end
            end
            DONE:    w_ctrl_nxt = IDLE;
            default: w_ctrl_nxt = IDLE;
        endcase
    end

    // Controller state register
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_ctrl <= IDLE;
        end else begin
            r_ctrl <= w_ctrl_nxt;
        end
    end

    // FSM state, step counter and sticky config-error flag
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_idle && start) begin
                r_state <= init_state;
                r_cnt   <= steps;
                r_err   <= 1'b0;
            end else if (r_ctrl == RUN) begin
                r_state <= w_nxt;
                r_cnt   <= r_cnt - CW'(1);
            end
            if (cfg_valid && !w_idle) begin
                r_err <= 1'b1;
            end
        end
    end

    assign cfg_ready = w_idle;
    assign state     = r_state;
    assign saida     = w_entry[OW-1:0];
    assign busy      = (r_ctrl == RUN);
    assign done      = (r_ctrl == DONE);
    assign err       = r_err;

endmodule

// File: tb/tb_fsm_table_sequencer.sv
// Self-checking bench for fsm_table_sequencer: table-driven vectors
// plus a per-cycle scoreboard of expected outputs during runs.
module tb_fsm_table_sequencer;

    logic       clk = 1'b0;
    logic       res;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [3:0] cfg_addr;
    logic [5:0] cfg_data;
    logic       start;
    logic [2:0] init_state;
    logic [7:0] steps;
    logic       a;
    logic [2:0] state;
    logic [2:0] saida;
    logic       busy;
    logic       done;
    logic       err;

    always #5 clk = ~clk;

    fsm_table_sequencer dut (
        .clk        (clk),
        .res        (res),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .start      (start),
        .init_state (init_state),
        .steps      (steps),
        .a          (a),
        .state      (state),
        .saida      (saida),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        logic [2:0] st;
        logic [2:0] sd;
        logic       bsy;
        logic       dn;
        logic       rdy;
        logic       er;
    } exp_t;

    typedef struct {
        logic [3:0] ad;
        logic [5:0] d;
    } cfg_t;

    typedef struct {
        logic [2:0] ini;
        logic       av;
        logic [2:0] sd;
    } vec_t;

    exp_t       q[$];
    logic [5:0] tab[16];
    cfg_t       ld[10];
    vec_t       vt[12];
    int         n_cmp  = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [3:0] ad, input logic [5:0] d);
        cfg_valid = 1'b1;
        cfg_addr  = ad;
        cfg_data  = d;
        #1;
        chk($sformatf("cfg_ready_wr%0d", ad), int'(cfg_ready), 1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        tab[ad] = d;
    endtask

    // Drive a start, push the expected per-cycle outputs, then
    // pop and compare one record per cycle. inj >= 0 drives an
    // illegal cfg write (and an ignored start) during RUN cycle inj.
    task automatic run(input string tag, input logic [2:0] ini,
                       input int n, input logic av, input int inj,
                       input logic w, input logic [3:0] wa,
                       input logic [5:0] wd);
        logic [2:0] st;
        logic [5:0] e;
        exp_t       r;
        int         k;
        if (w) begin
            cfg_valid = 1'b1;
            cfg_addr  = wa;
            cfg_data  = wd;
            tab[wa]   = wd;
        end
        start      = 1'b1;
        init_state = ini;
        steps      = n[7:0];
        a          = av;
        st = ini;
        for (int i = 0; i <= n + 1; i++) begin
            e     = tab[{av, st}];
            r.st  = st;
            r.sd  = e[2:0];
            r.bsy = (i < n);
            r.dn  = (i == n);
            r.rdy = (i > n);
            r.er  = (inj >= 0 && i > inj);
            q.push_back(r);
            if (i < n) st = e[5:3];
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        k = 0;
        while (q.size() > 0) begin
            r = q.pop_front();
            chk($sformatf("%s_state_c%0d", tag, k), int'(state), int'(r.st));
            chk($sformatf("%s_saida_c%0d", tag, k), int'(saida), int'(r.sd));
            chk($sformatf("%s_busy_c%0d", tag, k), int'(busy), int'(r.bsy));
            chk($sformatf("%s_done_c%0d", tag, k), int'(done), int'(r.dn));
            chk($sformatf("%s_rdy_c%0d", tag, k), int'(cfg_ready), int'(r.rdy));
            chk($sformatf("%s_err_c%0d", tag, k), int'(err), int'(r.er));
            if (k == inj) begin
                cfg_valid  = 1'b1;
                cfg_addr   = 4'd2;
                cfg_data   = 6'd0;
                start      = 1'b1;
                init_state = 3'd5;
            end
            @(posedge clk);
            #1;
            cfg_valid = 1'b0;
            start     = 1'b0;
            k++;
        end
    endtask

    initial begin
        ld[0] = '{4'd2,  6'd34};
        ld[1] = '{4'd10, 6'd34};
        ld[2] = '{4'd4,  6'd52};
        ld[3] = '{4'd12, 6'd12};
        ld[4] = '{4'd6,  6'd62};
        ld[5] = '{4'd14, 6'd62};
        ld[6] = '{4'd7,  6'd23};
        ld[7] = '{4'd15, 6'd39};
        ld[8] = '{4'd1,  6'd49};
        ld[9] = '{4'd9,  6'd49};

        vt[0]  = '{3'd2, 1'b0, 3'd2};
        vt[1]  = '{3'd2, 1'b1, 3'd2};
        vt[2]  = '{3'd4, 1'b0, 3'd4};
        vt[3]  = '{3'd4, 1'b1, 3'd4};
        vt[4]  = '{3'd6, 1'b0, 3'd6};
        vt[5]  = '{3'd6, 1'b1, 3'd6};
        vt[6]  = '{3'd7, 1'b0, 3'd7};
        vt[7]  = '{3'd7, 1'b1, 3'd7};
        vt[8]  = '{3'd1, 1'b0, 3'd1};
        vt[9]  = '{3'd1, 1'b1, 3'd1};
        vt[10] = '{3'd3, 1'b0, 3'd0};
        vt[11] = '{3'd5, 1'b1, 3'd0};

        for (int i = 0; i < 16; i++) tab[i] = 6'd0;

        res        = 1'b1;
        cfg_valid  = 1'b0;
        cfg_addr   = 4'd0;
        cfg_data   = 6'd0;
        start      = 1'b0;
        init_state = 3'd0;
        steps      = 8'd0;
        a          = 1'b0;
        #1;
        res = 1'b0;
        #2;
        chk("rst_saida_a0", int'(saida), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        a = 1'b1;
        #1;
        chk("rst_saida_a1", int'(saida), 0);
        a = 1'b0;
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 10; i++) wr(ld[i].ad, ld[i].d);

        run("s1", 3'd2, 4, 1'b0, -1, 1'b0, 4'd0, 6'd0);
        chk("s1_final", int'(state), 2);

        run("s2", 3'd2, 5, 1'b1, -1, 1'b0, 4'd0, 6'd0);
        chk("s2_final", int'(state), 4);

        run("s0", 3'd6, 0, 1'b0, -1, 1'b0, 4'd0, 6'd0);
        chk("s0_final", int'(state), 6);

        for (int i = 0; i < 12; i++) begin
            run($sformatf("v%0d", i), vt[i].ini, 0, 1'b0, -1,
                1'b0, 4'd0, 6'd0);
            a = vt[i].av;
            #1;
            chk($sformatf("vec%0d_saida", i), int'(saida), int'(vt[i].sd));
            chk($sformatf("vec%0d_state", i), int'(state), int'(vt[i].ini));
        end

        run("wrst", 3'd2, 1, 1'b0, -1, 1'b1, 4'd2, 6'd40);
        chk("wrst_final", int'(state), 5);
        wr(4'd2, 6'd34);

        run("err", 3'd2, 5, 1'b1, 2, 1'b0, 4'd0, 6'd0);
        chk("err_sticky", int'(err), 1);
        run("rerun", 3'd2, 5, 1'b1, -1, 1'b0, 4'd0, 6'd0);
        chk("rerun_final", int'(state), 4);
        chk("rerun_err", int'(err), 0);

        run("max", 3'd2, 255, 1'b0, -1, 1'b0, 4'd0, 6'd0);
        chk("max_final", int'(state), 7);

        start      = 1'b1;
        init_state = 3'd2;
        steps      = 8'd5;
        a          = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_busy_pre", int'(busy), 1);
        res = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) tab[i] = 6'd0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_state", int'(state), 0);
        chk("abort_saida", int'(saida), 0);
        chk("abort_done", int'(done), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort_hold_done%0d", i), int'(done), 0);
        end
        @(negedge clk);
        res = 1'b1;
        @(posedge clk);
        #1;
        run("post", 3'd2, 3, 1'b0, -1, 1'b0, 4'd0, 6'd0);
        chk("post_final", int'(state), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
